// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Takes decoded instruction fields, packs them into 32-bit instruction
//   words and writes them to consecutive instruction-memory addresses.
//   This is how the Harvard program store gets loaded. A small FIFO sits
//   between field acceptance and the memory write handshake, so tuples can
//   keep arriving while the memory holds off its acknowledge.
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   start, base_addr         begin a session in IDLE; base_addr is the first address
//   in_valid / in_ready      field-tuple handshake
//   in_opcode .. in_rsrc_add decoded instruction fields
//   in_last                  marks the final tuple of the session
//   imem_we/addr/wdata       memory write request, held stable until imem_ack
//   imem_ack                 memory takes the write in this cycle
//   busy, done               session status; done is a one-cycle pulse
//   word_count               number of words written in this session
//   err_illegal, err_wrap    sticky session errors
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rdst2,
  input  logic [4:0]        in_rdst1,
  input  logic [4:0]        in_rsrc2,
  input  logic [4:0]        in_rsrc1,
  input  logic [15:0]       in_imm,
  input  logic [7:0]        in_rdst_add,
  input  logic [7:0]        in_rsrc_add,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_wrap
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Pack one field tuple into an instruction word; unused bits stay 0.
  // Only legal opcodes (0x00..0x10) reach this, so everything past STORE
  // is treated as R-type.
  function automatic logic [31:0] encode(
    input logic [5:0]  op,
    input logic [4:0]  rdst2,
    input logic [4:0]  rdst1,
    input logic [4:0]  rsrc2,
    input logic [4:0]  rsrc1,
    input logic [15:0] imm,
    input logic [7:0]  rdst_add,
    input logic [7:0]  rsrc_add
  );
    logic [31:0] w;
    w        = '0;
    w[31:26] = op;
    if (op == 6'h00) begin
      w[25:21] = rdst2;
      w[15:0]  = imm;
    end else if (op == 6'h01) begin
      w[25:21] = rdst2;
      w[4:0]   = rsrc2;
    end else if (op == 6'h02) begin
      w[25:21] = rdst2;
      w[7:0]   = rsrc_add;
    end else if (op == 6'h03) begin
      w[25:18] = rdst_add;
      w[4:0]   = rsrc2;
    end else begin
      w[25:21] = rdst2;
      w[20:16] = rdst1;
      w[9:5]   = rsrc2;
      w[4:0]   = rsrc1;
    end
    return w;
  endfunction

  state_t              state_q, state_d;
  logic [31:0]         fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     word_count_q;
  logic                err_illegal_q, err_wrap_q;

  logic fifo_full, fifo_empty;
  logic accept, legal, push, pop;
  logic [31:0] enc_word;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);

  assign accept   = in_valid && in_ready;
  assign legal    = (in_opcode <= 6'h10);
  // Illegal tuples are consumed from the producer but never buffered.
  assign push     = accept && legal;
  // imem_we is only ever high in ACTIVE/DRAIN, so an ack outside a pending
  // write cannot pop anything.
  assign pop      = we_q && imem_ack;
  assign enc_word = encode(in_opcode, in_rdst2, in_rdst1, in_rsrc2, in_rsrc1,
                           in_imm, in_rdst_add, in_rsrc_add);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACTIVE;
      S_ACTIVE: if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN:  if (fifo_empty && !we_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = (state_q == S_ACTIVE) && !fifo_full;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // The write request is registered: it reflects the FIFO occupancy after
  // this edge, so a word pushed at edge N is presented right after it.
  always_comb begin
    we_d = ((state_d == S_ACTIVE) || (state_d == S_DRAIN)) && (count_d != '0);
  end

  // Buffer storage carries data only; pointers and count track validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      we_q    <= we_d;
    end
  end

  // Session bookkeeping: address, word count and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      word_count_q  <= '0;
      err_illegal_q <= 1'b0;
      err_wrap_q    <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      addr_q        <= base_addr;
      word_count_q  <= '0;
      err_illegal_q <= 1'b0;
      err_wrap_q    <= 1'b0;
    end else begin
      if (pop) begin
        addr_q       <= addr_q + ADDR_W'(1);
        word_count_q <= word_count_q + (ADDR_W+1)'(1);
        if (addr_q == {ADDR_W{1'b1}}) err_wrap_q <= 1'b1;
      end
      if (accept && !legal) err_illegal_q <= 1'b1;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  // Head of the FIFO is stable while the request is pending because pushes
  // never target the slot under the read pointer unless the FIFO is empty.
  assign imem_wdata  = we_q ? fifo_q[rd_ptr_q] : 32'h0;
  assign word_count  = word_count_q;
  assign err_illegal = err_illegal_q;
  assign err_wrap    = err_wrap_q;

endmodule
